spy_readout_ctrl: RTL
=====================

Name: spy_readout_ctrl

Overview:
- Sequences a set of NCH spy capture buffers through arm, fill and readout.
- Releases each channel's capture lock, waits for every enabled channel to fill its 2^AW-word RAM, then drains the channels one at a time.
- Each drained channel goes onto a single valid/ready stream toward the host/DAQ link.
- Sits between the per-channel spy write controllers and spy RAMs on one side and the readout link on the other.

Parameters:
NCH, 4, number of spy channels (1..8)
AW, 11, spy RAM address width; each channel holds 2^AW words
DW, 16, sample/stream word width (>=16)
TIMEOUT_CYC, 1048576, max cycles spent waiting for channels to fill

Ports:
clk  in  1  clock
reset  in  1  reset
sw_arm  in  1  single-cycle start pulse from control register
ch_mask  in  NCH  enabled channels; sampled on accepted sw_arm
ch_rearm  out  NCH  one-cycle pulse per channel; drives capture lock release
ch_full  in  NCH  level; channel capture complete (locked)
rd_en  out  1  spy RAM read strobe
rd_ch  out  3  channel being read
rd_addr  out  AW  RAM read address
rd_data  in  NCH*DW  concatenated RAM outputs; channel k at bits [k*DW +: DW]; valid 1 cycle after rd_en
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_data  out  DW  stream word
m_ch  out  3  channel of current word
m_last  out  1  last word of a channel block
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on entering IDLE from DONE
timeout_err  out  1  sticky; channel fill timed out

Behaviour:
- Reset values: all outputs 0.
  - State IDLE; rr_ptr=0; timeout counter=0.
  - Skid buffer empty.
  - Any in-flight RAM read data is discarded.
- sw_arm is accepted only in IDLE; it is ignored elsewhere.
  - On acceptance: latch ch_mask to mask_q and clear timeout_err.
- If mask_q == 0: go straight to DONE.
- States:
  - IDLE: on accepted sw_arm -> ARM.
  - ARM: one cycle. ch_rearm = mask_q. -> WAIT.
  - WAIT: counter increments each cycle.
    - If (ch_full & mask_q) == mask_q: pending = mask_q -> SELECT.
    - Else if counter == TIMEOUT_CYC-1: timeout_err=1, pending = ch_full & mask_q -> SELECT.
    - ch_full is ignored during the first 2 cycles of WAIT, so lock release can propagate.
  - SELECT: one cycle.
    - If pending == 0: -> DONE.
    - Else cur = first set bit of pending at or after rr_ptr, searching ascending and wrapping. -> READ.
  - READ: streams addresses 0..2^AW-1 of channel cur.
    - After the last word is accepted: clear pending[cur], rr_ptr = (cur+1) mod NCH -> SELECT.
  - DONE: done=1 for one cycle -> IDLE.
- Read pipeline, READ state:
  - RAM latency is exactly 1 cycle.
  - Output path is the m_* register plus one skid entry (capacity 2).
  - rd_en is asserted when (occupancy + in-flight) < 2 and addresses remain.
  - rd_addr increments on each rd_en.
  - Full throughput of 1 word/cycle is sustained while m_ready=1.
  - While m_valid=1 and m_ready=0, m_data, m_ch and m_last hold stable.
  - m_last=1 only on address 2^AW-1.
- Words leave in strict address order. No word is dropped or duplicated under any m_ready pattern.
- rd_addr wraps to 0 at the start of each channel block.
- rd_ch = cur while in READ; 0 otherwise.
- Reset asserted mid-READ: m_valid falls on the next edge and the block returns to IDLE. ch_rearm is not issued.
- A channel whose ch_full drops during READ is still read fully; ch_full is not re-checked.

Optional Feature:
SPY_HEADER_EN
- Defined: each channel block is preceded by one header word.
  - Header m_data = {8'hA5, (DW-8)-bit zero-extended channel index}.
  - m_ch = cur; m_last=0.
  - The header occupies one stream beat before address 0. Block length is 2^AW+1 beats.
- Not defined: no header; blocks are exactly 2^AW beats.

Test Plan:
- mask=4'b1111; all ch_full rise 100 cycles after ARM; m_ready=1 -> ch_rearm=4'hF for 1 cycle. Four blocks of 2048 beats in order ch0..3. Data equals the RAM model. done pulse; timeout_err=0.
- mask=4'b0101; random m_ready at 30% duty -> only ch0 then ch2 streamed. No drop or duplicate; m_last on each word 2047; outputs stable while stalled.
- TIMEOUT_CYC=64; mask=4'b0011; only ch1 fills -> timeout_err=1 at cycle 64 of WAIT. Only ch1 streamed; done pulse.
- Round robin across runs: after a timeout run that ends on ch1 (rr_ptr=2), a full run with mask=4'hF streams order ch2,ch3,ch0,ch1.
- reset asserted at beat 500 of ch0 -> m_valid=0 next cycle, busy=0. A sw_arm during READ in another run is ignored.
- SPY_HEADER_EN defined, mask=4'b1000 -> first beat m_data=16'hA503, then 2048 data beats.

Source files
------------

// File: rtl/spy_readout_ctrl.sv
// Spy buffer readout sequencer: arm, wait for fill (with timeout), then round-robin drain of
// each channel onto one valid/ready stream. Define SPY_HEADER_EN to prefix each block with a header.
module spy_readout_ctrl #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned AW          = 11,
    parameter int unsigned DW          = 16,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_arm,
    input  logic [NCH-1:0]    ch_mask,
    output logic [NCH-1:0]    ch_rearm,
    input  logic [NCH-1:0]    ch_full,
    output logic              rd_en,
    output logic [2:0]        rd_ch,
    output logic [AW-1:0]     rd_addr,
    input  logic [NCH*DW-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [2:0]        m_ch,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);
    localparam int unsigned   TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]    NCH_L     = 4'(NCH);
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {StIdle, StArm, StWait, StSelect, StRead, StDone} state_e;

    state_e          state_q, state_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [7:0]      pend_q, pend_d;
    logic [2:0]      rr_q, rr_d, cur_q, cur_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            to_err_q, to_err_d;
    logic [NCH-1:0]  rearm_q, rearm_d;
    logic            done_q, done_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            issued_q, issued_d;
    logic            infl_q, infl_d, infl_last_q, infl_last_d;
    logic            out_v_q, out_v_d, out_last_q, out_last_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [2:0]      out_ch_q, out_ch_d;
    logic            skid_v_q, skid_v_d, skid_last_q, skid_last_d;
    logic [DW-1:0]   skid_data_q, skid_data_d;

    logic            sel_found;
    logic [2:0]      sel_idx;
    logic [3:0]      probe;
    logic [DW-1:0]   in_data;
    logic            pop, rd_en_c, all_full;
    logic [1:0]      load;

    // Round-robin pick: first pending channel at or after rr_q, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        probe     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            probe = {1'b0, rr_q} + 4'(i);
            if (probe >= NCH_L) probe = probe - NCH_L;
            if (!sel_found && pend_q[probe[2:0]]) begin
                sel_found = 1'b1;
                sel_idx   = probe[2:0];
            end
        end
    end

    always_comb begin
        in_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (cur_q == 3'(k)) in_data = rd_data[k*DW +: DW];
        end
    end

    assign all_full = (ch_full & mask_q) == mask_q;
    assign pop      = out_v_q & m_ready;
    // Occupancy after this cycle's pop plus the read in flight must leave room for one more.
    assign load     = 2'(out_v_q) + 2'(skid_v_q) + 2'(infl_q) - 2'(pop);
    assign rd_en_c  = (state_q == StRead) && !issued_q && (load < 2'd2);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        pend_d      = pend_q;
        rr_d        = rr_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        to_err_d    = to_err_q;
        rearm_d     = '0;
        done_d      = 1'b0;
        addr_d      = addr_q;
        issued_d    = issued_q;
        infl_d      = rd_en_c;
        infl_last_d = rd_en_c && (addr_q == LAST_ADDR);
        out_v_d     = out_v_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        skid_v_d    = skid_v_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;

        if (rd_en_c) begin
            addr_d = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) issued_d = 1'b1;
        end

        if (pop) begin
            if (skid_v_q) begin
                out_data_d = skid_data_q;
                out_last_d = skid_last_q;
                skid_v_d   = 1'b0;
            end else begin
                out_v_d = 1'b0;
            end
        end
        if (infl_q) begin
            if (!out_v_d) begin
                out_v_d    = 1'b1;
                out_data_d = in_data;
                out_last_d = infl_last_q;
                out_ch_d   = cur_q;
            end else begin
                skid_v_d    = 1'b1;
                skid_data_d = in_data;
                skid_last_d = infl_last_q;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (sw_arm) begin
                    mask_d   = ch_mask;
                    to_err_d = 1'b0;
                    if (ch_mask == '0) begin
                        state_d = StDone;
                    end else begin
                        rearm_d = ch_mask;
                        state_d = StArm;
                    end
                end
            end
            StArm: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // First two cycles ignore ch_full so the lock release can propagate.
                if (cnt_q >= TW'(2) && all_full) begin
                    pend_d  = 8'(mask_q);
                    state_d = StSelect;
                end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    to_err_d = 1'b1;
                    pend_d   = 8'(ch_full & mask_q);
                    state_d  = StSelect;
                end
            end
            StSelect: begin
                addr_d   = '0;
                issued_d = 1'b0;
                if (!sel_found) begin
                    state_d = StDone;
                end else begin
                    cur_d   = sel_idx;
                    state_d = StRead;
`ifdef SPY_HEADER_EN
                    out_v_d    = 1'b1;
                    out_data_d = {8'hA5, (DW-8)'(sel_idx)};
                    out_last_d = 1'b0;
                    out_ch_d   = sel_idx;
`endif
                end
            end
            StRead: begin
                if (pop && out_last_q) begin
                    pend_d[cur_q] = 1'b0;
                    rr_d          = (cur_q == 3'(NCH - 1)) ? 3'd0 : cur_q + 3'd1;
                    state_d       = StSelect;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            pend_q      <= '0;
            rr_q        <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            to_err_q    <= 1'b0;
            rearm_q     <= '0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            issued_q    <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            out_v_q     <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            skid_v_q    <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            to_err_q    <= to_err_d;
            rearm_q     <= rearm_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            out_v_q     <= out_v_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            skid_v_q    <= skid_v_d;
            skid_last_q <= skid_last_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign ch_rearm    = rearm_q;
    assign rd_en       = rd_en_c;
    assign rd_ch       = (state_q == StRead) ? cur_q : 3'd0;
    assign rd_addr     = addr_q;
    assign m_valid     = out_v_q;
    assign m_data      = out_data_q;
    assign m_ch        = out_ch_q;
    assign m_last      = out_last_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign timeout_err = to_err_q;

endmodule
